// File: rtl/count_multi_tick_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : count_multi_tick_if                                             |
// | Purpose  : Control/status bundle for the multi-channel tick generator.     |
// |            o_tick_cnt exists only when COUNT_TICK_CNT_EN is defined.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface count_multi_tick_if #(
  parameter int N_CH    = 4,
  parameter int NB_SEL  = 2,
  parameter int NB_TCNT = 8
);
  logic [N_CH-1:0]        i_enable;
  logic [N_CH*NB_SEL-1:0] i_sel;
  logic [N_CH-1:0]        i_mode;
  logic                   i_sync;
  logic [N_CH-1:0]        o_tick;
  logic [N_CH-1:0]        o_busy;

  if (NB_TCNT < 1) begin : g_bad_tcnt
    $error("count_multi_tick_if: NB_TCNT must be at least 1");
  end

`ifdef COUNT_TICK_CNT_EN
  logic [N_CH*NB_TCNT-1:0] o_tick_cnt;

  modport master (
    output i_enable, i_sel, i_mode, i_sync,
    input  o_tick, o_busy, o_tick_cnt
  );

  modport slave (
    input  i_enable, i_sel, i_mode, i_sync,
    output o_tick, o_busy, o_tick_cnt
  );
`else
  modport master (
    output i_enable, i_sel, i_mode, i_sync,
    input  o_tick, o_busy
  );

  modport slave (
    input  i_enable, i_sel, i_mode, i_sync,
    output o_tick, o_busy
  );
`endif
endinterface
`default_nettype wire

// File: rtl/count_multi_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : count_multi_tick                                                |
// | Purpose  : N_CH independent power-of-two tick generators, periodic or      |
// |            one-shot. Define COUNT_TICK_CNT_EN for per-channel tick counts. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module count_multi_tick #(
  parameter int N_CH       = 4,
  parameter int NB_COUNTER = 32,
  parameter int NB_SEL     = 2,
  parameter int BASE_SHIFT = 21,
  parameter int NB_TCNT    = 8
) (
  input wire                clock,
  input wire                i_reset,
  count_multi_tick_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [NB_COUNTER-1:0] c_ONE = NB_COUNTER'(1);

  if (BASE_SHIFT >= NB_COUNTER || BASE_SHIFT < (1 << NB_SEL) || NB_TCNT < 1) begin : g_cfg_check
    $error("count_multi_tick: illegal parameter combination");
  end

  logic [N_CH-1:0] w_tick;
  logic [N_CH-1:0] w_busy;
`ifdef COUNT_TICK_CNT_EN
  logic [N_CH*NB_TCNT-1:0] w_tick_cnt;
`endif

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    state_t                  state_q;
    logic [NB_COUNTER-1:0]   cnt_q;
    logic [NB_SEL-1:0]       sel_q;
    logic                    mode_q;
    logic                    tick_q;
    logic                    busy_q;
    logic                    en_d;
    logic [NB_SEL-1:0]       sel_d;
    logic                    mode_d;
    logic [NB_COUNTER-1:0]   last_d;
    logic                    wrap_d;
`ifdef COUNT_TICK_CNT_EN
    logic [NB_TCNT-1:0]      tcnt_q;
`endif

    assign en_d   = bus.i_enable[c];
    assign sel_d  = bus.i_sel[c*NB_SEL +: NB_SEL];
    assign mode_d = bus.i_mode[c];
    // Terminal count P-1 for the latched selector, P = 2**(BASE_SHIFT-sel).
    assign last_d = (c_ONE << (BASE_SHIFT - int'(sel_q))) - c_ONE;
    assign wrap_d = (state_q == S_RUN) && en_d && (cnt_q == last_d);

    always_ff @(posedge clock or negedge i_reset) begin
      if (!i_reset) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        sel_q   <= '0;
        mode_q  <= 1'b0;
        tick_q  <= 1'b0;
        busy_q  <= 1'b0;
`ifdef COUNT_TICK_CNT_EN
        tcnt_q  <= '0;
`endif
      end else begin
        tick_q <= 1'b0;
        if (bus.i_sync) begin
          // Restart overrides a coincident tick and any pause.
          cnt_q  <= '0;
          sel_q  <= sel_d;
          mode_q <= mode_d;
`ifdef COUNT_TICK_CNT_EN
          tcnt_q <= '0;
`endif
          if (state_q == S_RUN || en_d) begin
            state_q <= S_RUN;
            busy_q  <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end else begin
          case (state_q)
            S_IDLE: begin
              cnt_q <= '0;
              if (en_d) begin
                state_q <= S_RUN;
                busy_q  <= 1'b1;
                sel_q   <= sel_d;
                mode_q  <= mode_d;
              end
            end
            S_RUN: begin
              if (wrap_d) begin
                tick_q <= 1'b1;
                cnt_q  <= '0;
`ifdef COUNT_TICK_CNT_EN
                tcnt_q <= tcnt_q + NB_TCNT'(1);
`endif
                if (mode_q) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
                end else begin
                  sel_q  <= sel_d;
                  mode_q <= mode_d;
                end
              end else if (en_d) begin
                cnt_q <= cnt_q + c_ONE;
              end
            end
            S_DONE: begin
              cnt_q <= '0;
              if (!en_d) begin
                state_q <= S_IDLE;
              end
            end
            default: begin
              state_q <= S_IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
            end
          endcase
        end
      end
    end

    assign w_tick[c] = tick_q;
    assign w_busy[c] = busy_q;
`ifdef COUNT_TICK_CNT_EN
    assign w_tick_cnt[c*NB_TCNT +: NB_TCNT] = tcnt_q;
`endif
  end

  assign bus.o_tick = w_tick;
  assign bus.o_busy = w_busy;
`ifdef COUNT_TICK_CNT_EN
  assign bus.o_tick_cnt = w_tick_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_count_multi_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_count_multi_tick                                             |
// | Purpose  : Vector table plus directed sequences for count_multi_tick.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_count_multi_tick;
  localparam int c_BS = 4;

  logic        clock   = 1'b0;
  logic        i_reset = 1'b1;
  int unsigned cyc     = 0;
  int          n_cmp   = 0;
  int          n_err   = 0;
  bit          mon_en  = 1'b0;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  mask;
  } ev_t;

  typedef struct {
    logic [3:0] en;
    logic [7:0] sel;
    logic [3:0] mode;
    int         cycles;
    logic [3:0] exp_busy;
  } vec_t;

  ev_t  sb[$];
  vec_t vecs[6];

  count_multi_tick_if #(.N_CH(4), .NB_SEL(2), .NB_TCNT(2)) bus ();

  count_multi_tick #(
    .N_CH(4), .NB_COUNTER(32), .NB_SEL(2), .BASE_SHIFT(c_BS), .NB_TCNT(2)
  ) dut (
    .clock  (clock),
    .i_reset(i_reset),
    .bus    (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(int unsigned c, logic [3:0] m);
    int   i = 0;
    ev_t  e;
    while (i < sb.size() && sb[i].cyc < c) i++;
    if (i < sb.size() && sb[i].cyc == c) begin
      e = sb[i];
      e.mask = e.mask | m;
      sb[i] = e;
    end else begin
      e.cyc  = c;
      e.mask = m;
      sb.insert(i, e);
    end
  endfunction

  task automatic mon_step();
    logic [3:0] exp_m;
    exp_m = 4'd0;
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_m = sb[0].mask;
      void'(sb.pop_front());
    end
    if (bus.o_tick != 4'd0 || exp_m != 4'd0) check("tick", 32'(bus.o_tick), 32'(exp_m));
  endtask

  task automatic wait_neg(int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic drive(logic [3:0] en, logic [7:0] sel, logic [3:0] mode);
    bus.i_enable = en;
    bus.i_sel    = sel;
    bus.i_mode   = mode;
  endtask

  // Caller sits just after a falling edge; reset lands mid-cycle.
  task automatic do_reset();
    mon_en = 1'b0;
    #1 i_reset = 1'b0;
    #1;
    check("rst_tick", 32'(bus.o_tick), 32'd0);
    check("rst_busy", 32'(bus.o_busy), 32'd0);
`ifdef COUNT_TICK_CNT_EN
    check("rst_tcnt", 32'(bus.o_tick_cnt), 32'd0);
`endif
    sb.delete();
    wait_neg(1);
    drive(4'd0, 8'd0, 4'd0);
    bus.i_sync = 1'b0;
    i_reset    = 1'b1;
    mon_en     = 1'b1;
  endtask

  task automatic run_vec(vec_t v);
    int unsigned base;
    logic [3:0]  m;
    int          p;
    logic [7:0]  s;
    s = v.sel;
    drive(v.en, v.sel, v.mode);
    base = cyc + 1;
    for (int t = 1; t <= v.cycles; t++) begin
      m = 4'd0;
      for (int c = 0; c < 4; c++) begin
        if (v.en[c]) begin
          p = 1 << (c_BS - int'(s[c*2 +: 2]));
          if (v.mode[c] ? (t == p) : (t % p == 0)) m[c] = 1'b1;
        end
      end
      if (m != 4'd0) push_ev(base + t, m);
    end
    wait_neg(v.cycles + 1);
    check("busy_end", 32'(bus.o_busy), 32'(v.exp_busy));
    check("sb_empty", sb.size(), 32'd0);
    do_reset();
  endtask

  initial begin
    int unsigned base;
    drive(4'd0, 8'd0, 4'd0);
    bus.i_sync = 1'b0;

    vecs[0] = '{4'b0001, 8'h00, 4'b0000, 50, 4'b0001};
    vecs[1] = '{4'b1111, 8'he4, 4'b0000, 20, 4'b1111};
    vecs[2] = '{4'b0100, 8'h20, 4'b0100, 12, 4'b0000};
    vecs[3] = '{4'b1010, 8'hc8, 4'b0010, 10, 4'b1000};
    vecs[4] = '{4'b0000, 8'hff, 4'b0000, 10, 4'b0000};
    vecs[5] = '{4'b0011, 8'h01, 4'b0011, 12, 4'b0010};

    fork
      forever begin
        @(negedge clock);
        if (mon_en) mon_step();
      end
    join_none

    wait_neg(1);
    do_reset();

    foreach (vecs[i]) run_vec(vecs[i]);

    // Pause at count 10 for 5 cycles: tick at 21 instead of 16.
    drive(4'b0001, 8'h00, 4'b0000);
    base = cyc + 1;
    push_ev(base + 21, 4'b0001);
    wait_neg(11);
    check("busy_run", 32'(bus.o_busy), 32'h1);
    bus.i_enable = 4'b0000;
    wait_neg(5);
    check("busy_pause", 32'(bus.o_busy), 32'h1);
    bus.i_enable = 4'b0001;
    wait_neg(6);
    bus.i_enable = 4'b0000;
    check("pause_sb", sb.size(), 32'd0);
    do_reset();

    // Pause exactly at P-1: the tick waits for the first enabled edge.
    drive(4'b0001, 8'h00, 4'b0000);
    base = cyc + 1;
    push_ev(base + 19, 4'b0001);
    push_ev(base + 35, 4'b0001);
    wait_neg(16);
    bus.i_enable = 4'b0000;
    wait_neg(3);
    bus.i_enable = 4'b0001;
    wait_neg(17);
    bus.i_enable = 4'b0000;
    check("pmax_sb", sb.size(), 32'd0);
    do_reset();

    // ch1 sel 1->3 mid-period: spacing 8 until the wrap, then 2.
    drive(4'b0010, 8'h04, 4'b0000);
    base = cyc + 1;
    push_ev(base + 8, 4'b0010);
    push_ev(base + 10, 4'b0010);
    push_ev(base + 12, 4'b0010);
    wait_neg(4);
    bus.i_sel = 8'h0c;
    wait_neg(10);
    bus.i_enable = 4'b0000;
    wait_neg(2);
    check("selchg_sb", sb.size(), 32'd0);
    do_reset();

    // One-shot, then re-arm by dropping and raising enable.
    drive(4'b0100, 8'h20, 4'b0100);
    base = cyc + 1;
    push_ev(base + 4, 4'b0100);
    wait_neg(3);
    check("os_busy_run", 32'(bus.o_busy), 32'h4);
    wait_neg(5);
    check("os_busy_done", 32'(bus.o_busy), 32'h0);
    bus.i_enable = 4'b0000;
    wait_neg(1);
    bus.i_enable = 4'b0100;
    base = cyc + 1;
    push_ev(base + 4, 4'b0100);
    wait_neg(8);
    check("os_busy_done2", 32'(bus.o_busy), 32'h0);
    check("os_sb", sb.size(), 32'd0);
    do_reset();

    // Sync on a ch3 tick edge; ends with an asynchronous reset mid-count.
    drive(4'b1001, 8'hc0, 4'b0000);
    base = cyc + 1;
    push_ev(base + 2, 4'b1000);
    for (int k = 6; k <= 20; k += 2) push_ev(base + k, 4'b1000);
    push_ev(base + 20, 4'b0001);
    wait_neg(4);
    bus.i_sync = 1'b1;
    wait_neg(1);
    bus.i_sync = 1'b0;
    check("sync_busy", 32'(bus.o_busy), 32'h9);
    wait_neg(16);
    check("sync_tick_live", 32'(bus.o_tick), 32'h9);
    check("sync_sb", sb.size(), 32'd0);
    do_reset();

`ifdef COUNT_TICK_CNT_EN
    drive(4'b0001, 8'h03, 4'b0000);
    base = cyc + 1;
    for (int k = 1; k <= 5; k++) push_ev(base + 2 * k, 4'b0001);
    wait_neg(1);
    for (int k = 1; k <= 5; k++) begin
      wait_neg(2);
      check("tcnt", 32'(bus.o_tick_cnt[1:0]), 32'(k % 4));
    end
    bus.i_sync = 1'b1;
    wait_neg(1);
    bus.i_sync   = 1'b0;
    bus.i_enable = 4'b0000;
    check("tcnt_sync", 32'(bus.o_tick_cnt[1:0]), 32'd0);
    wait_neg(2);
    check("tcnt_sb", sb.size(), 32'd0);
    do_reset();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/count_multi_tick.md
Name: count_multi_tick

Overview:
- Multi-channel programmable tick generator; parametrised successor to the single-channel LED-sweep timing counter.
- Each of N_CH channels has its own counter, a selectable power-of-two period, an enable, and periodic or one-shot mode.
- Output is a single-cycle tick per channel, not a sticky valid. It drives shift registers and LED sweep logic, one channel per sweep pattern.

Parameters:
- N_CH, 4, number of independent channels.
- NB_COUNTER, 32, width of each channel counter.
- NB_SEL, 2, width of each channel's period selector (2**NB_SEL periods).
- BASE_SHIFT, 21, period for selector k is 2**(BASE_SHIFT-k) cycles. Requires BASE_SHIFT < NB_COUNTER and BASE_SHIFT >= 2**NB_SEL.
- NB_TCNT, 8, width of the per-channel tick counter (optional feature only).

Ports:
- clock  in  1  system clock, all logic on rising edge.
- i_reset  in  1  asynchronous, active-low reset.
- i_enable  in  N_CH  per-channel run enable, bit c belongs to channel c.
- i_sel  in  N_CH*NB_SEL  per-channel period select, channel c at bits [c*NB_SEL +: NB_SEL].
- i_mode  in  N_CH  per-channel mode: 0 = periodic, 1 = one-shot.
- i_sync  in  1  synchronous restart of all channels, counters cleared together.
- o_tick  out  N_CH  one-cycle tick pulse per channel.
- o_busy  out  N_CH  1 while the channel is in RUN.
- o_tick_cnt  out  N_CH*NB_TCNT  running tick count per channel (only with COUNT_TICK_CNT_EN).

Behaviour:
- Reset (i_reset=0, asynchronous): every counter = 0, every channel in IDLE, latched sel/mode = 0. Outputs: o_tick = 0, o_busy = 0, o_tick_cnt = 0.
- Per-channel FSM has three states:
  - IDLE: counter = 0. Goes to RUN on i_enable[c]=1, latching i_sel and i_mode on the same edge.
  - RUN: counter increments each cycle while i_enable[c]=1. With i_enable[c]=0 the counter holds and no tick fires (pause, not clear).
  - DONE (one-shot only): counter = 0, o_busy = 0. Returns to IDLE when i_enable[c]=0.
- Period P = 2**(BASE_SHIFT - sel_latched).
- Tick: in RUN with enable high and counter == P-1:
  - o_tick[c]=1 on the next cycle (registered, exactly one cycle wide).
  - counter wraps to 0.
  - Periodic mode: i_sel and i_mode are re-latched at the wrap and stay in RUN. Mid-period changes take effect only at the next period boundary.
  - One-shot mode: go to DONE.
- First tick timing: with enable held, the first tick appears P cycles after the IDLE->RUN edge. Periodic ticks are then spaced exactly P cycles apart.
- i_sync=1: all channels clear their counters to 0 and re-latch sel/mode.
  - RUN stays RUN; DONE and IDLE go to IDLE when enable is low, and to RUN when enable is high.
  - A tick coinciding with i_sync is suppressed. i_sync has priority over tick and pause.
- Pause exactly at counter == P-1: no tick. The tick fires on the first enabled cycle after resume.
- The counter never exceeds P-1. Arithmetic is unsigned, width NB_COUNTER, and the comparison is against the zero-extended P-1.
- Channels are fully independent; simultaneous ticks on several channels are all reported in the same cycle.

Optional Feature:
- Macro: COUNT_TICK_CNT_EN.
- Defined:
  - o_tick_cnt is present. Each channel has an NB_TCNT-bit counter incremented on every tick it emits, wrapping from 2**NB_TCNT-1 to 0.
  - Cleared by reset and by i_sync; not cleared by disable.
- Not defined: the port and its registers are absent; all other behaviour is identical.

Test Plan:
- Periodic, sel 0: BASE_SHIFT=4, ch0 sel=0, mode=0, enable high -> o_tick[0] pulses at cycles 16, 32, 48 after enable; each pulse is 1 cycle wide; o_busy[0]=1 throughout.
- Selector sweep: ch0..ch3 sel=0,1,2,3 -> tick spacing 16, 8, 4, 2 cycles. Changing ch1 sel 1->3 mid-period keeps spacing 8 until the next wrap, then 2.
- One-shot: ch2 mode=1, sel=2 -> a single tick 4 cycles after enable, then o_busy[2]=0 and no further ticks. Dropping and re-raising enable gives another tick 4 cycles later.
- Pause: ch0 sel=0; drop enable at count 10 for 5 cycles -> tick arrives 21 cycles after enable, not 16.
- Sync and reset: assert i_sync on the cycle ch3 would tick -> no tick, all counters 0, next ch3 tick 2 cycles later. Assert i_reset=0 asynchronously mid-count -> o_tick, o_busy and o_tick_cnt are 0 immediately, before the next clock edge.
- Optional feature (with COUNT_TICK_CNT_EN, NB_TCNT=2): 5 ticks on ch0 -> o_tick_cnt ch0 = 1, 2, 3, 0, 1; i_sync clears it to 0.
